output_serializer_fifo: RTL and testbench
=========================================

// Module: output_serializer_fifo
// PURPOSE
//  Parametrised parallel-in/serial-out output stage for the FP adder result path.
//  Buffers up to DEPTH result words in a FIFO and streams them out one bit per
//  accepted read, back-to-back across words with no gap cycles. Adds selectable
//  bit order, frame markers, a fill level, a flush and sticky overflow reporting.
// PARAMETERS
//  WIDTH      32  bits per word (>=2)
//  DEPTH      4   FIFO depth in words, power of two, >=2
//  MSB_FIRST  0   0: bit 0 shifted first; 1: bit WIDTH-1 shifted first
// PORTS
//  clk_in          in   1                    clock, all logic on rising edge
//  rst_n_in        in   1                    asynchronous active-low reset
//  parallel_in     in   WIDTH                word to enqueue
//  wr_in           in   1                    write request; accepted when input_rdy=1
//  flush_in        in   1                    sync clear of FIFO, bit counter, overflow
//  output_read_in  in   1                    shift request; accepted when output_rdy=1
//  input_rdy       out  1                    FIFO not full
//  output_rdy      out  1                    FIFO not empty (a bit is available)
//  serial_out      out  1                    registered serial data
//  serial_valid    out  1                    serial_out holds a new bit this cycle
//  serial_first    out  1                    with serial_valid: first bit of a word
//  serial_last     out  1                    with serial_valid: last bit of a word
//  level           out  $clog2(DEPTH)+1      words held, 0..DEPTH (partly sent word counts)
//  overflow        out  1                    sticky: write attempted while full
// BEHAVIOUR
//  Reset (async, rst_n_in=0): FIFO empty, pointers/bit counter 0, serial_out=0,
//   serial_valid=0, serial_first=0, serial_last=0, overflow=0; hence input_rdy=1,
//   output_rdy=0, level=0. Asserting reset mid-word discards all state instantly.
//  input_rdy = (level!=DEPTH); output_rdy = (level!=0); both combinational from state.
//  Write: wr_in&&input_rdy at edge -> parallel_in stored at tail, level+1.
//   wr_in&&!input_rdy -> word dropped, overflow<=1 (stays 1 until flush/reset).
//  Read: output_read_in&&output_rdy at edge -> serial_out<=head[idx], serial_valid<=1,
//   idx = bit_cnt (MSB_FIRST=0) or WIDTH-1-bit_cnt (MSB_FIRST=1);
//   serial_first<=(bit_cnt==0); serial_last<=(bit_cnt==WIDTH-1); bit_cnt+1.
//   On the bit_cnt==WIDTH-1 read: pop head, bit_cnt<=0, level-1; next read cycle
//   shifts bit 0 of the next word (no bubble).
//  No accepted read: serial_valid/first/last<=0, serial_out holds last value.
//  Read with output_rdy=0 is ignored (no underflow, no flag).
//  Latency: word written at edge N -> output_rdy=1 after edge N -> earliest first
//   bit on serial_out after edge N+1. Full word drain = WIDTH accepted reads.
//  Simultaneous write + final-bit pop: both take effect, level unchanged.
//  Write while full is refused even if the same edge pops (input_rdy from
//   current state only); sets overflow.
//  Flush: highest priority over write/read in that cycle; clears FIFO, bit_cnt,
//   overflow, serial_valid/first/last; serial_out<=0. Write in flush cycle is lost,
//   does not set overflow.
//  Pointers are log2(DEPTH) bits, wrap naturally; level tracks full vs empty.
// TESTING
//  1 Reset, write 32'hA5A5_0001, 32 reads (MSB_FIRST=0) -> bits 1,0,0,0,...; first on
//    read 1, last on read 32; output_rdy=0 after pop, input_rdy stays 1.
//  2 MSB_FIRST=1, write 32'h8000_0001 -> serial 1, thirty 0s, 1; first/last flagged.
//  3 Write 4 words (DEPTH=4) -> input_rdy=0, level=4; 5th write dropped, overflow=1;
//    64 continuous reads -> word0 then word1 bits with no idle cycle.
//  4 Full FIFO, write on final-bit pop edge -> refused, overflow=1, level=3 after.
//  5 Level=2, write on final-bit pop edge -> accepted, level stays 2.
//  6 Mid-word (bit 10) assert flush, then separately rst_n_in=0 -> level=0,
//    output_rdy=0, serial_valid=0, overflow=0; next word starts at bit 0.

Source files
------------

// File: rtl/output_serializer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : output_serializer_fifo
//  Purpose  : FIFO-buffered parallel-in/serial-out stage for the FP adder
//             result path. Words stream out bit by bit with no inter-word gap.
//  Revision : 1.0  initial release
// ============================================================================
module output_serializer_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [WIDTH-1:0]         parallel_in,
    input  logic                     wr_in,
    input  logic                     flush_in,
    input  logic                     output_read_in,
    output logic                     input_rdy,
    output logic                     output_rdy,
    output logic                     serial_out,
    output logic                     serial_valid,
    output logic                     serial_first,
    output logic                     serial_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_BW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_BW-1:0]  r_bit_cnt;
    logic [c_AW:0]    r_level;
    logic             r_overflow;
    logic             r_sout;
    logic             r_svalid;
    logic             r_sfirst;
    logic             r_slast;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_last_bit;
    logic             w_pop;
    logic [c_BW-1:0]  w_idx;
    logic [WIDTH-1:0] w_head;

    assign input_rdy  = (r_level != (c_AW+1)'(DEPTH));
    assign output_rdy = (r_level != '0);

    // Flush takes priority, so it masks both handshakes.
    assign w_wr_acc   = wr_in && input_rdy && !flush_in;
    assign w_rd_acc   = output_read_in && output_rdy && !flush_in;
    assign w_last_bit = (r_bit_cnt == c_BW'(WIDTH-1));
    assign w_pop      = w_rd_acc && w_last_bit;
    assign w_head     = r_mem[r_rd_ptr];

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_idx = c_BW'(WIDTH-1) - r_bit_cnt;
        end else begin : g_lsb_first
            assign w_idx = r_bit_cnt;
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= parallel_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_bit_cnt  <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_sout     <= 1'b0;
            r_svalid   <= 1'b0;
            r_sfirst   <= 1'b0;
            r_slast    <= 1'b0;
        end else if (flush_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_bit_cnt  <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_sout     <= 1'b0;
            r_svalid   <= 1'b0;
            r_sfirst   <= 1'b0;
            r_slast    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            // Refusal is judged on the pre-edge level, even if this edge pops.
            if (wr_in && !input_rdy) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_acc) begin
                r_sout    <= w_head[w_idx];
                r_svalid  <= 1'b1;
                r_sfirst  <= (r_bit_cnt == '0);
                r_slast   <= w_last_bit;
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + c_BW'(1);
            end else begin
                r_svalid  <= 1'b0;
                r_sfirst  <= 1'b0;
                r_slast   <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_level <= r_level + (c_AW+1)'(1);
                2'b01:   r_level <= r_level - (c_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign serial_out   = r_sout;
    assign serial_valid = r_svalid;
    assign serial_first = r_sfirst;
    assign serial_last  = r_slast;
    assign level        = r_level;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_output_serializer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_serializer_fifo
//  Purpose  : Self-checking bench; LSB-first and MSB-first instances share
//             stimulus and are compared against a queue-based word model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_output_serializer_fifo;

    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         wr = 1'b0, fl = 1'b0, rd = 1'b0;

    logic       a_irdy, a_ordy, a_so, a_sv, a_sf, a_sl, a_ovf;
    logic [2:0] a_lvl;
    logic       b_irdy, b_ordy, b_so, b_sv, b_sf, b_sl, b_ovf;
    logic [2:0] b_lvl;

    output_serializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_in(clk), .rst_n_in(rst_n), .parallel_in(din), .wr_in(wr),
        .flush_in(fl), .output_read_in(rd), .input_rdy(a_irdy), .output_rdy(a_ordy),
        .serial_out(a_so), .serial_valid(a_sv), .serial_first(a_sf),
        .serial_last(a_sl), .level(a_lvl), .overflow(a_ovf));

    output_serializer_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut_msb (
        .clk_in(clk), .rst_n_in(rst_n), .parallel_in(din), .wr_in(wr),
        .flush_in(fl), .output_read_in(rd), .input_rdy(b_irdy), .output_rdy(b_ordy),
        .serial_out(b_so), .serial_valid(b_sv), .serial_first(b_sf),
        .serial_last(b_sl), .level(b_lvl), .overflow(b_ovf));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of whole words plus the index of the next bit.
    logic [W-1:0] m_q[$];
    int           m_cnt;
    bit           m_ovf, m_s0, m_s1, m_v, m_f, m_l;

    function automatic void model_clear();
        m_q.delete();
        m_cnt = 0; m_ovf = 0; m_s0 = 0; m_s1 = 0; m_v = 0; m_f = 0; m_l = 0;
    endfunction

    task automatic tick(input bit w, input logic [W-1:0] d, input bit r, input bit f);
        logic [W-1:0] head;
        bit           full;
        wr = w; din = d; rd = r; fl = f;
        if (f) begin
            model_clear();
        end else begin
            full = (m_q.size() == D);
            head = (m_q.size() != 0) ? m_q[0] : '0;
            if (r && m_q.size() != 0) begin
                m_s0 = head[m_cnt];
                m_s1 = head[W-1-m_cnt];
                m_v = 1; m_f = (m_cnt == 0); m_l = (m_cnt == W-1);
                if (m_cnt == W-1) begin
                    void'(m_q.pop_front());
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_v = 0; m_f = 0; m_l = 0;
            end
            if (w) begin
                if (!full) m_q.push_back(d);
                else       m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        wr = 0; rd = 0; fl = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (a_lvl !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", a_lvl); end
        n_checks++; if (a_irdy !== 1'b1 || a_ordy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got irdy=%b ordy=%b want 1 0", a_irdy, a_ordy); end
        n_checks++; if ({a_so, a_sv, a_sf, a_sl, a_ovf} !== 5'b0) begin n_fail++; $display("FAIL reset_serial: got %b want 00000", {a_so, a_sv, a_sf, a_sl, a_ovf}); end
        n_checks++; if ({b_so, b_sv, b_ovf, b_lvl} !== 6'b0) begin n_fail++; $display("FAIL reset_msb: got %b want 0", {b_so, b_sv, b_ovf, b_lvl}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lsb_word();
        logic [W-1:0] v = 32'hA5A5_0001;
        tick(1, v, 0, 0);
        n_checks++; if (a_ordy !== 1'b1) begin n_fail++; $display("FAIL latency_ordy: got %b want 1", a_ordy); end
        for (int i = 0; i < W; i++) begin
            tick(0, '0, 1, 0);
            n_checks++;
            if (a_so !== v[i] || a_sv !== 1'b1 || a_sf !== (i == 0) || a_sl !== (i == W-1)) begin
                n_fail++;
                $display("FAIL lsb_bit%0d: got so=%b v=%b f=%b l=%b want so=%b v=1 f=%b l=%b",
                         i, a_so, a_sv, a_sf, a_sl, v[i], (i == 0), (i == W-1));
            end
        end
        n_checks++; if (a_ordy !== 1'b0 || a_irdy !== 1'b1) begin n_fail++; $display("FAIL lsb_drain_rdy: got ordy=%b irdy=%b want 0 1", a_ordy, a_irdy); end
    endtask

    task automatic test_msb_word();
        logic [W-1:0] v = 32'h8000_0001;
        tick(1, v, 0, 0);
        for (int i = 0; i < W; i++) begin
            tick(0, '0, 1, 0);
            n_checks++;
            if (b_so !== ((i == 0) || (i == W-1)) || b_sf !== (i == 0) || b_sl !== (i == W-1)) begin
                n_fail++;
                $display("FAIL msb_bit%0d: got so=%b f=%b l=%b want so=%b f=%b l=%b",
                         i, b_so, b_sf, b_sl, ((i == 0) || (i == W-1)), (i == 0), (i == W-1));
            end
        end
    endtask

    task automatic test_full_overflow();
        tick(0, '0, 0, 1);
        for (int i = 0; i < D; i++) tick(1, $urandom, 0, 0);
        n_checks++; if (a_irdy !== 1'b0 || a_lvl !== 3'd4) begin n_fail++; $display("FAIL full: got irdy=%b lvl=%0d want 0 4", a_irdy, a_lvl); end
        tick(1, $urandom, 0, 0);
        n_checks++; if (a_ovf !== 1'b1 || a_lvl !== 3'd4) begin n_fail++; $display("FAIL overflow: got ovf=%b lvl=%0d want 1 4", a_ovf, a_lvl); end
        for (int i = 0; i < 2*W; i++) begin
            tick(0, '0, 1, 0);
            n_checks++;
            if (a_sv !== 1'b1 || a_so !== m_s0 || b_so !== m_s1) begin
                n_fail++;
                $display("FAIL stream_bit%0d: got v=%b a=%b b=%b want v=1 a=%b b=%b", i, a_sv, a_so, b_so, m_s0, m_s1);
            end
        end
        n_checks++; if (a_lvl !== 3'd2 || a_ovf !== 1'b1) begin n_fail++; $display("FAIL stream_end: got lvl=%0d ovf=%b want 2 1", a_lvl, a_ovf); end
    endtask

    task automatic test_full_pop_write();
        tick(0, '0, 0, 1);
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b want 0", a_ovf); end
        for (int i = 0; i < D; i++) tick(1, $urandom, 0, 0);
        for (int i = 0; i < W-1; i++) tick(0, '0, 1, 0);
        tick(1, 32'hDEAD_BEEF, 1, 0);
        n_checks++; if (a_lvl !== 3'd3 || a_ovf !== 1'b1 || a_sl !== 1'b1) begin n_fail++; $display("FAIL full_pop_write: got lvl=%0d ovf=%b last=%b want 3 1 1", a_lvl, a_ovf, a_sl); end
    endtask

    task automatic test_level2_pop_write();
        tick(0, '0, 0, 1);
        for (int i = 0; i < 2; i++) tick(1, $urandom, 0, 0);
        for (int i = 0; i < W-1; i++) tick(0, '0, 1, 0);
        tick(1, $urandom, 1, 0);
        n_checks++; if (a_lvl !== 3'd2 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL lvl2_pop_write: got lvl=%0d ovf=%b want 2 0", a_lvl, a_ovf); end
        for (int i = 0; i < 2*W; i++) begin
            tick(0, '0, 1, 0);
            n_checks++; if (a_so !== m_s0 || b_so !== m_s1) begin n_fail++; $display("FAIL lvl2_drain%0d: got a=%b b=%b want a=%b b=%b", i, a_so, b_so, m_s0, m_s1); end
        end
        n_checks++; if (a_ordy !== 1'b0) begin n_fail++; $display("FAIL lvl2_empty: got ordy=%b want 0", a_ordy); end
    endtask

    task automatic test_flush_reset();
        logic [W-1:0] v;
        tick(0, '0, 0, 1);
        for (int i = 0; i <= D; i++) tick(1, $urandom, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, '0, 1, 0);
        tick(1, $urandom, 1, 1);
        n_checks++;
        if (a_lvl !== 3'd0 || a_ordy !== 1'b0 || a_sv !== 1'b0 || a_ovf !== 1'b0 || a_so !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mid: got lvl=%0d ordy=%b v=%b ovf=%b so=%b want 0 0 0 0 0", a_lvl, a_ordy, a_sv, a_ovf, a_so);
        end
        v = $urandom | 32'h1;
        tick(1, v, 0, 0);
        tick(0, '0, 1, 0);
        n_checks++; if (a_sf !== 1'b1 || a_so !== v[0] || b_so !== v[W-1]) begin n_fail++; $display("FAIL flush_restart: got f=%b a=%b b=%b want 1 %b %b", a_sf, a_so, b_so, v[0], v[W-1]); end
        for (int i = 0; i < 9; i++) tick(0, '0, 1, 0);
        tick(1, $urandom, 0, 0);
        tick(1, $urandom, 0, 0);
        tick(1, $urandom, 0, 0);
        tick(1, $urandom, 0, 0);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (a_lvl !== 3'd0 || a_ordy !== 1'b0 || a_sv !== 1'b0 || a_ovf !== 1'b0 || b_lvl !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: got lvl=%0d ordy=%b v=%b ovf=%b want 0 0 0 0", a_lvl, a_ordy, a_sv, a_ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = $urandom;
        tick(1, v, 0, 0);
        tick(0, '0, 1, 0);
        n_checks++; if (a_sf !== 1'b1 || a_so !== v[0] || b_so !== v[W-1]) begin n_fail++; $display("FAIL reset_restart: got f=%b a=%b b=%b want 1 %b %b", a_sf, a_so, b_so, v[0], v[W-1]); end
        tick(0, '0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) < 15), $urandom, ($urandom_range(0, 99) < 80),
                 ($urandom_range(0, 199) == 0));
            n_checks++;
            if (a_so !== m_s0 || b_so !== m_s1 || a_sv !== m_v || a_sf !== m_f || a_sl !== m_l ||
                a_lvl !== 3'(m_q.size()) || a_ovf !== m_ovf ||
                a_irdy !== (m_q.size() != D) || a_ordy !== (m_q.size() != 0)) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got so=%b/%b v=%b f=%b l=%b lvl=%0d ovf=%b want so=%b/%b v=%b f=%b l=%b lvl=%0d ovf=%b",
                         i, a_so, b_so, a_sv, a_sf, a_sl, a_lvl, a_ovf,
                         m_s0, m_s1, m_v, m_f, m_l, m_q.size(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_word();
        test_msb_word();
        test_full_overflow();
        test_full_pop_write();
        test_level2_pop_write();
        test_flush_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
